// File: rtl/jesd204_rx_sync_header_lock_ctrl.sv
// 64B66B sync-header block-lock controller: hunts for header alignment by
// pulsing rxgearboxslip, declares block_lock, and monitors for loss of lock.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | disabled or in reset; counters cleared, outputs low
// ST_HUNT      | counting consecutive valid headers toward lock
// ST_SLIP_WAIT | slip just issued; headers ignored until the gearbox settles
// ST_LOCKED    | aligned; invalid headers counted per monitoring window
module jesd204_rx_sync_header_lock_ctrl #(
    parameter int SH_CNT_LOCK    = 64,
    parameter int SH_WINDOW      = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       header_valid,
    input  logic [1:0] header,
    output logic       rxgearboxslip,
    output logic       block_lock,
    output logic       lock_lost,
    output logic [7:0] slip_count,
    output logic [1:0] state
);

    localparam int SHW  = $clog2(SH_CNT_LOCK) + 1;
    localparam int WINW = $clog2(SH_WINDOW) + 1;
    localparam int INVW = $clog2(SH_INVALID_MAX) + 1;

    // Compare against "limit - 1" so a counter never has to hold its limit.
    localparam logic [SHW-1:0]  SH_LAST   = SHW'(SH_CNT_LOCK - 1);
    localparam logic [WINW-1:0] WIN_LAST  = WINW'(SH_WINDOW - 1);
    localparam logic [INVW-1:0] INV_LAST  = INVW'(SH_INVALID_MAX - 1);
    localparam logic [7:0]      WAIT_LOAD = 8'(SLIP_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HUNT      = 2'd1,
        ST_SLIP_WAIT = 2'd2,
        ST_LOCKED    = 2'd3
    } state_t;

    state_t          state_q;
    logic [SHW-1:0]  sh_cnt_q;
    logic [WINW-1:0] win_cnt_q;
    logic [INVW-1:0] inv_cnt_q;
    logic [7:0]      wait_cnt_q;
    logic [7:0]      slip_count_q;
    logic            rxgearboxslip_q;
    logic            block_lock_q;
    logic            lock_lost_q;

    logic            hdr_bad_d;
    logic            hdr_good_d;
    logic [7:0]      slip_count_d;

    always_comb begin
        hdr_bad_d    = header_valid && (header[1] == header[0]);
        hdr_good_d   = header_valid && (header[1] != header[0]);
        slip_count_d = (slip_count_q == 8'hFF) ? slip_count_q : slip_count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            sh_cnt_q        <= '0;
            win_cnt_q       <= '0;
            inv_cnt_q       <= '0;
            wait_cnt_q      <= '0;
            slip_count_q    <= '0;
            rxgearboxslip_q <= 1'b0;
            block_lock_q    <= 1'b0;
            lock_lost_q     <= 1'b0;
        end else begin
            rxgearboxslip_q <= 1'b0;
            lock_lost_q     <= 1'b0;
            if (!enable) begin
                // Disable overrides everything, including a lock-loss on the same header.
                state_q      <= ST_IDLE;
                sh_cnt_q     <= '0;
                win_cnt_q    <= '0;
                inv_cnt_q    <= '0;
                wait_cnt_q   <= '0;
                slip_count_q <= '0;
                block_lock_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q  <= ST_HUNT;
                        sh_cnt_q <= '0;
                    end
                    ST_HUNT: begin
                        if (hdr_bad_d) begin
                            rxgearboxslip_q <= 1'b1;
                            slip_count_q    <= slip_count_d;
                            wait_cnt_q      <= WAIT_LOAD;
                            sh_cnt_q        <= '0;
                            state_q         <= ST_SLIP_WAIT;
                        end else if (hdr_good_d) begin
                            if (sh_cnt_q == SH_LAST) begin
                                block_lock_q <= 1'b1;
                                sh_cnt_q     <= '0;
                                win_cnt_q    <= '0;
                                inv_cnt_q    <= '0;
                                state_q      <= ST_LOCKED;
                            end else begin
                                sh_cnt_q <= sh_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_SLIP_WAIT: begin
                        if (wait_cnt_q == 8'd0) begin
                            sh_cnt_q <= '0;
                            state_q  <= ST_HUNT;
                        end else begin
                            wait_cnt_q <= wait_cnt_q - 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (header_valid) begin
                            if (hdr_bad_d && (inv_cnt_q == INV_LAST)) begin
                                block_lock_q    <= 1'b0;
                                lock_lost_q     <= 1'b1;
                                rxgearboxslip_q <= 1'b1;
                                slip_count_q    <= slip_count_d;
                                wait_cnt_q      <= WAIT_LOAD;
                                win_cnt_q       <= '0;
                                inv_cnt_q       <= '0;
                                state_q         <= ST_SLIP_WAIT;
                            end else if (win_cnt_q == WIN_LAST) begin
                                win_cnt_q <= '0;
                                inv_cnt_q <= '0;
                            end else begin
                                win_cnt_q <= win_cnt_q + 1'b1;
                                if (hdr_bad_d) begin
                                    inv_cnt_q <= inv_cnt_q + 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign rxgearboxslip = rxgearboxslip_q;
    assign block_lock    = block_lock_q;
    assign lock_lost     = lock_lost_q;
    assign slip_count    = slip_count_q;
    assign state         = state_q;

endmodule

// File: tb/tb_jesd204_rx_sync_header_lock_ctrl.sv
// Directed bench for the sync-header lock controller with default parameters
// (lock 64, window 64, invalid limit 16, slip wait 32).
module tb_jesd204_rx_sync_header_lock_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       header_valid = 1'b0;
    logic [1:0] header = 2'b00;
    logic       rxgearboxslip;
    logic       block_lock;
    logic       lock_lost;
    logic [7:0] slip_count;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    jesd204_rx_sync_header_lock_ctrl #(
        .SH_CNT_LOCK(64),
        .SH_WINDOW(64),
        .SH_INVALID_MAX(16),
        .SLIP_WAIT(32)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .header_valid(header_valid),
        .header(header),
        .rxgearboxslip(rxgearboxslip),
        .block_lock(block_lock),
        .lock_lost(lock_lost),
        .slip_count(slip_count),
        .state(state)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic step(input logic v, input logic [1:0] h);
        header_valid = v;
        header       = h;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go_hunt();
        enable = 1'b0;
        step(1'b0, 2'b00);
        enable = 1'b1;
        step(1'b0, 2'b00);
    endtask

    task automatic wait_out_slip();
        repeat (33) step(1'b0, 2'b00);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rxgearboxslip, block_lock, lock_lost, slip_count, state} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got slip=%b lock=%b lost=%b cnt=%0d st=%0d, want all 0",
                     rxgearboxslip, block_lock, lock_lost, slip_count, state);
        end
        resetn = 1'b1;
        repeat (10) step(1'b1, 2'b11);
        n_tests++;
        if ({rxgearboxslip, block_lock, lock_lost, slip_count, state} !== 13'd0) begin
            n_fail++;
            $display("FAIL idle_disabled: got slip=%b lock=%b lost=%b cnt=%0d st=%0d, want all 0",
                     rxgearboxslip, block_lock, lock_lost, slip_count, state);
        end
    endtask

    task automatic test_clean_lock();
        int slips = 0;
        go_hunt();
        n_tests++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL hunt_entry: state=%0d want 1", state);
        end
        for (int i = 1; i <= 64; i++) begin
            step(1'b1, 2'b01);
            slips += int'(rxgearboxslip);
            if (i == 63) begin
                n_tests++;
                if (block_lock !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clean_lock_early: block_lock=%b after 63 headers want 0", block_lock);
                end
            end
        end
        n_tests++;
        if (block_lock !== 1'b1 || state !== 2'd3) begin
            n_fail++;
            $display("FAIL clean_lock: block_lock=%b state=%0d want 1/3", block_lock, state);
        end
        n_tests++;
        if (slips != 0 || slip_count !== 8'd0) begin
            n_fail++;
            $display("FAIL clean_lock_noslip: pulses=%0d slip_count=%0d want 0/0", slips, slip_count);
        end
    endtask

    task automatic test_gapped_lock();
        int nvalid = 0;
        int slips = 0;
        go_hunt();
        for (int i = 0; i < 128; i++) begin
            if (i % 2 == 0) begin
                step(1'b1, 2'b10);
                nvalid++;
            end else begin
                step(1'b0, 2'b11);
            end
            slips += int'(rxgearboxslip);
            if (i % 2 == 0 && nvalid == 63) begin
                n_tests++;
                if (block_lock !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gapped_lock_early: block_lock=%b after 63 valid want 0", block_lock);
                end
            end
            if (i % 2 == 0 && nvalid == 64) begin
                n_tests++;
                if (block_lock !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gapped_lock: block_lock=%b after 64 valid want 1", block_lock);
                end
            end
        end
        n_tests++;
        if (slips != 0) begin
            n_fail++;
            $display("FAIL gapped_noslip: pulses=%0d want 0", slips);
        end
    endtask

    task automatic test_hunt_slip();
        int slips = 0;
        go_hunt();
        repeat (5) step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        n_tests++;
        if (rxgearboxslip !== 1'b1 || slip_count !== 8'd1 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL hunt_slip: slip=%b cnt=%0d st=%0d want 1/1/2", rxgearboxslip, slip_count, state);
        end
        for (int i = 1; i <= 33; i++) begin
            step(1'b1, 2'b00);
            slips += int'(rxgearboxslip);
            if (i == 32) begin
                n_tests++;
                if (state !== 2'd2) begin
                    n_fail++;
                    $display("FAIL slip_wait_hold: state=%0d at wait 32 want 2", state);
                end
            end
        end
        n_tests++;
        if (slips != 0 || state !== 2'd1 || slip_count !== 8'd1) begin
            n_fail++;
            $display("FAIL slip_wait_ignore: pulses=%0d st=%0d cnt=%0d want 0/1/1", slips, state, slip_count);
        end
        repeat (64) step(1'b1, 2'b01);
        n_tests++;
        if (block_lock !== 1'b1 || slip_count !== 8'd1) begin
            n_fail++;
            $display("FAIL relock_after_slip: lock=%b cnt=%0d want 1/1", block_lock, slip_count);
        end
    endtask

    task automatic test_loss_of_lock();
        int lost = 0;
        go_hunt();
        repeat (64) step(1'b1, 2'b01);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, (i < 15) ? 2'b11 : 2'b10);
            lost += int'(lock_lost) + int'(rxgearboxslip);
        end
        n_tests++;
        if (block_lock !== 1'b1 || lost != 0) begin
            n_fail++;
            $display("FAIL window_15_invalid: lock=%b pulses=%0d want 1/0", block_lock, lost);
        end
        repeat (10) step(1'b1, 2'b01);
        repeat (15) step(1'b1, 2'b00);
        n_tests++;
        if (block_lock !== 1'b1 || lock_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL window_reset: lock=%b lost=%b after 15 invalid want 1/0", block_lock, lock_lost);
        end
        step(1'b1, 2'b11);
        n_tests++;
        if (block_lock !== 1'b0 || lock_lost !== 1'b1 || rxgearboxslip !== 1'b1 ||
            slip_count !== 8'd1 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL lock_loss: lock=%b lost=%b slip=%b cnt=%0d st=%0d want 0/1/1/1/2",
                     block_lock, lock_lost, rxgearboxslip, slip_count, state);
        end
        step(1'b0, 2'b00);
        n_tests++;
        if (lock_lost !== 1'b0 || rxgearboxslip !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_pulse_width: lost=%b slip=%b want 0/0", lock_lost, rxgearboxslip);
        end
    endtask

    task automatic test_boundary();
        go_hunt();
        repeat (63) step(1'b1, 2'b01);
        step(1'b1, 2'b00);
        n_tests++;
        if (block_lock !== 1'b0 || rxgearboxslip !== 1'b1 || slip_count !== 8'd1 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL hunt_64th_invalid: lock=%b slip=%b cnt=%0d st=%0d want 0/1/1/2",
                     block_lock, rxgearboxslip, slip_count, state);
        end
        wait_out_slip();
        repeat (64) step(1'b1, 2'b10);
        repeat (48) step(1'b1, 2'b01);
        repeat (15) step(1'b1, 2'b11);
        n_tests++;
        if (block_lock !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_prelock: lock=%b want 1", block_lock);
        end
        step(1'b1, 2'b11);
        n_tests++;
        if (block_lock !== 1'b0 || lock_lost !== 1'b1 || slip_count !== 8'd2) begin
            n_fail++;
            $display("FAIL invalid_beats_window: lock=%b lost=%b cnt=%0d want 0/1/2",
                     block_lock, lock_lost, slip_count);
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        go_hunt();
        for (int i = 1; i <= 300; i++) begin
            step(1'b1, 2'b00);
            pulses += int'(rxgearboxslip);
            if (i == 255) begin
                n_tests++;
                if (slip_count !== 8'd255) begin
                    n_fail++;
                    $display("FAIL slip_count_255: got %0d want 255", slip_count);
                end
            end
            wait_out_slip();
        end
        n_tests++;
        if (slip_count !== 8'd255 || pulses != 300) begin
            n_fail++;
            $display("FAIL slip_saturate: cnt=%0d pulses=%0d want 255/300", slip_count, pulses);
        end
    endtask

    task automatic test_enable_drop();
        go_hunt();
        repeat (64) step(1'b1, 2'b01);
        enable = 1'b0;
        step(1'b1, 2'b11);
        n_tests++;
        if (state !== 2'd0 || block_lock !== 1'b0 || lock_lost !== 1'b0 || rxgearboxslip !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop_locked: st=%0d lock=%b lost=%b slip=%b want 0/0/0/0",
                     state, block_lock, lock_lost, rxgearboxslip);
        end
        enable = 1'b1;
        step(1'b0, 2'b00);
        step(1'b1, 2'b01);
        step(1'b1, 2'b01);
        enable = 1'b0;
        step(1'b1, 2'b11);
        n_tests++;
        if (rxgearboxslip !== 1'b0 || slip_count !== 8'd0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL enable_cuts_slip: slip=%b cnt=%0d st=%0d want 0/0/0", rxgearboxslip, slip_count, state);
        end
    endtask

    task automatic test_reset_mid_slip();
        go_hunt();
        repeat (3) step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        n_tests++;
        if (rxgearboxslip !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_slip: slip=%b want 1", rxgearboxslip);
        end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if (rxgearboxslip !== 1'b0 || slip_count !== 8'd0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset_mid_slip: slip=%b cnt=%0d st=%0d want 0/0/0", rxgearboxslip, slip_count, state);
        end
        @(negedge clk);
        resetn = 1'b1;
        step(1'b0, 2'b00);
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_gapped_lock();
        test_hunt_slip();
        test_loss_of_lock();
        test_boundary();
        test_saturation();
        test_enable_drop();
        test_reset_mid_slip();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
